// File: rtl/panzer16_bus_pkg.sv
// Shared types and constants for the panzer16 memory-bus arbiter.
package panzer16_bus_pkg;

  localparam int unsigned DATA_W = 16;
  localparam int unsigned ADDR_W = 16;

  localparam logic RW_READ  = 1'b0;
  localparam logic RW_WRITE = 1'b1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    I_XFER = 2'd1,
    D_XFER = 2'd2
  } arb_state_e;

endpackage

// File: rtl/bus_arb_pick.sv
// Grant selection between fetch and data requesters. With ARB_ROUND_ROBIN_EN
// defined priority alternates; otherwise data wins with a fetch starvation guard.
module bus_arb_pick
  import panzer16_bus_pkg::*;
#(
  parameter int unsigned D_BURST_MAX = 4
) (
  input  logic clk_i,
  input  logic rst_n_i,
  input  logic grant_en_i,
  input  logic ireq_i,
  input  logic dreq_i,
  input  logic itrans_i,
  output logic gnt_ifetch_c_o,
  output logic gnt_data_c_o
);

  logic i_wins_c;

`ifdef ARB_ROUND_ROBIN_EN
  logic i_prio_q, i_prio_d;
  logic unused_itrans;

  assign unused_itrans = itrans_i;

  always_comb begin
    i_wins_c       = ireq_i && (!dreq_i || i_prio_q);
    gnt_ifetch_c_o = grant_en_i && i_wins_c;
    gnt_data_c_o   = grant_en_i && dreq_i && !i_wins_c;
    i_prio_d       = i_prio_q;
    if (gnt_data_c_o) begin
      i_prio_d = 1'b1;
    end else if (gnt_ifetch_c_o) begin
      i_prio_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      i_prio_q <= 1'b0;
    end else begin
      i_prio_q <= i_prio_d;
    end
  end
`else
  localparam int unsigned STREAK_W = $clog2(D_BURST_MAX + 1);
  localparam logic [STREAK_W-1:0] BURST_MAX = STREAK_W'(D_BURST_MAX);

  logic [STREAK_W-1:0] streak_q, streak_d;

  // Streak saturates so a masked fetch cannot wrap the counter.
  always_comb begin
    i_wins_c       = ireq_i && (!dreq_i || (streak_q >= BURST_MAX));
    gnt_ifetch_c_o = grant_en_i && i_wins_c;
    gnt_data_c_o   = grant_en_i && dreq_i && !i_wins_c;
    streak_d       = streak_q;
    if (gnt_ifetch_c_o) begin
      streak_d = '0;
    end else if (gnt_data_c_o) begin
      if (!itrans_i) begin
        streak_d = '0;
      end else if (streak_q != BURST_MAX) begin
        streak_d = streak_q + STREAK_W'(1);
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      streak_q <= '0;
    end else begin
      streak_q <= streak_d;
    end
  end
`endif

endmodule

// File: rtl/bus_arbiter.sv
// Two-master arbiter (fetch / data) for the shared 16-bit memory bus with abort
// and timeout. Build option: ARB_ROUND_ROBIN_EN selects round-robin priority.
module bus_arbiter
  import panzer16_bus_pkg::*;
#(
  parameter int unsigned DATA_W      = panzer16_bus_pkg::DATA_W,
  parameter int unsigned ADDR_W      = panzer16_bus_pkg::ADDR_W,
  parameter int unsigned D_BURST_MAX = 4,
  parameter int unsigned TIMEOUT     = 255
) (
  input  logic              Clk,
  input  logic              RST,
  input  logic              ITrans,
  input  logic [ADDR_W-1:0] IAdress,
  input  logic              IAbort,
  output logic              IReady,
  output logic [DATA_W-1:0] IData,
  input  logic              DTrans,
  input  logic [ADDR_W-1:0] DAdress,
  input  logic              DReadWrite,
  input  logic [DATA_W-1:0] DWriteData,
  output logic              DReady,
  output logic [DATA_W-1:0] DData,
  output logic              BusTrans,
  output logic [ADDR_W-1:0] BusAdress,
  output logic              BusReadWrite,
  output logic [DATA_W-1:0] BusWriteData,
  input  logic [DATA_W-1:0] BusReadData,
  input  logic              BusReady,
  output logic              BusTimeout
);

  localparam int unsigned CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TIMEOUT - 1);

  arb_state_e        state_q, state_d;
  logic [CNT_W-1:0]  tmo_cnt_q, tmo_cnt_d;
  logic              drop_q, drop_d;
  logic              bus_trans_q, bus_trans_d;
  logic [ADDR_W-1:0] bus_addr_q, bus_addr_d;
  logic              bus_rw_q, bus_rw_d;
  logic [DATA_W-1:0] bus_wdata_q, bus_wdata_d;
  logic              iready_q, iready_d;
  logic [DATA_W-1:0] idata_q, idata_d;
  logic              dready_q, dready_d;
  logic [DATA_W-1:0] ddata_q, ddata_d;
  logic              timeout_q, timeout_d;

  logic              ireq_c, dreq_c, gnt_ifetch_c, gnt_data_c;
  logic [DATA_W-1:0] xfer_rdata_c;

  // A requester whose Ready is showing still holds Trans; ignore it this cycle.
  assign ireq_c = ITrans && !iready_q && !IAbort;
  assign dreq_c = DTrans && !dready_q;

  bus_arb_pick #(
    .D_BURST_MAX(D_BURST_MAX)
  ) u_pick (
    .clk_i         (Clk),
    .rst_n_i       (RST),
    .grant_en_i    (state_q == IDLE),
    .ireq_i        (ireq_c),
    .dreq_i        (dreq_c),
    .itrans_i      (ITrans),
    .gnt_ifetch_c_o(gnt_ifetch_c),
    .gnt_data_c_o  (gnt_data_c)
  );

  always_comb begin
    state_d      = state_q;
    tmo_cnt_d    = tmo_cnt_q;
    drop_d       = drop_q;
    bus_trans_d  = 1'b0;
    bus_addr_d   = bus_addr_q;
    bus_rw_d     = bus_rw_q;
    bus_wdata_d  = bus_wdata_q;
    iready_d     = 1'b0;
    idata_d      = idata_q;
    dready_d     = 1'b0;
    ddata_d      = ddata_q;
    timeout_d    = 1'b0;
    xfer_rdata_c = BusReady ? BusReadData : '0;

    unique case (state_q)
      IDLE: begin
        drop_d    = 1'b0;
        tmo_cnt_d = '0;
        if (gnt_ifetch_c) begin
          state_d     = I_XFER;
          bus_trans_d = 1'b1;
          bus_addr_d  = IAdress;
          bus_rw_d    = RW_READ;
        end else if (gnt_data_c) begin
          state_d     = D_XFER;
          bus_trans_d = 1'b1;
          bus_addr_d  = DAdress;
          bus_rw_d    = DReadWrite;
          bus_wdata_d = DWriteData;
        end
      end
      I_XFER, D_XFER: begin
        // BusReady takes precedence over an expiring timeout.
        if (BusReady || (tmo_cnt_q == TMO_LAST)) begin
          state_d   = IDLE;
          drop_d    = 1'b0;
          timeout_d = !BusReady;
          if (state_q == I_XFER) begin
            iready_d = !(drop_q || IAbort);
            if (iready_d) begin
              idata_d = xfer_rdata_c;
            end
          end else begin
            dready_d = 1'b1;
            ddata_d  = xfer_rdata_c;
          end
        end else begin
          bus_trans_d = 1'b1;
          tmo_cnt_d   = tmo_cnt_q + CNT_W'(1);
          if ((state_q == I_XFER) && IAbort) begin
            drop_d = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (!RST) begin
      state_q     <= IDLE;
      tmo_cnt_q   <= '0;
      drop_q      <= 1'b0;
      bus_trans_q <= 1'b0;
      bus_addr_q  <= '0;
      bus_rw_q    <= 1'b0;
      bus_wdata_q <= '0;
      iready_q    <= 1'b0;
      idata_q     <= '0;
      dready_q    <= 1'b0;
      ddata_q     <= '0;
      timeout_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      tmo_cnt_q   <= tmo_cnt_d;
      drop_q      <= drop_d;
      bus_trans_q <= bus_trans_d;
      bus_addr_q  <= bus_addr_d;
      bus_rw_q    <= bus_rw_d;
      bus_wdata_q <= bus_wdata_d;
      iready_q    <= iready_d;
      idata_q     <= idata_d;
      dready_q    <= dready_d;
      ddata_q     <= ddata_d;
      timeout_q   <= timeout_d;
    end
  end

  assign IReady       = iready_q;
  assign IData        = idata_q;
  assign DReady       = dready_q;
  assign DData        = ddata_q;
  assign BusTrans     = bus_trans_q;
  assign BusAdress    = bus_addr_q;
  assign BusReadWrite = bus_rw_q;
  assign BusWriteData = bus_wdata_q;
  assign BusTimeout   = timeout_q;

endmodule
